// File: rtl/eprisc_bus_arbiter.sv
// Two-port memory bus arbiter: IDLE -> ACCESS -> RESP, one transfer per 3 cycles.
// Define EPRISC_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module eprisc_bus_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [1:0]        iReq,
    input  logic [1:0]        iWrite,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iWData0,
    input  logic [DATA_W-1:0] iWData1,
    output logic [1:0]        oAck,
    output logic [DATA_W-1:0] oRData,
    output logic              oWrErr,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemWData,
    output logic              oMemWrite,
    output logic              oRomEn,
    output logic              oRamEn,
    input  logic [DATA_W-1:0] iMemRData
);

    localparam int unsigned REGION_BIT = ADDR_W - 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

    stateT             state, stateNext;
    logic              grantPort, grantPortNext;
    logic              latWrite, latWriteNext;
    logic              latRam, latRamNext;
    logic [1:0]        ackNext;
    logic [DATA_W-1:0] rDataNext;
    logic              wrErrNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memWDataNext;
    logic              memWriteNext;
    logic              romEnNext;
    logic              ramEnNext;

    logic              winner;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWData;
    logic              selWrite;
    logic              selRam;

`ifdef EPRISC_ARB_RR_EN
    logic lastGrant, lastGrantNext;

    // On a tie, grant the port that did not win last time.
    assign winner = (iReq == 2'b11) ? ~lastGrant : iReq[1];
`else
    // Fixed priority: port 0 wins whenever it requests.
    assign winner = ~iReq[0];
`endif

    assign selAddr  = winner ? iAddr1 : iAddr0;
    assign selWData = winner ? iWData1 : iWData0;
    assign selWrite = iWrite[winner];
    assign selRam   = selAddr[REGION_BIT];

    // Next-state and next-output logic; memory strobes are registered so they
    // are valid for the whole ACCESS cycle.
    always_comb begin
        stateNext     = state;
        grantPortNext = grantPort;
        latWriteNext  = latWrite;
        latRamNext    = latRam;
        ackNext       = 2'b00;
        rDataNext     = oRData;
        wrErrNext     = 1'b0;
        memAddrNext   = '0;
        memWDataNext  = '0;
        memWriteNext  = 1'b0;
        romEnNext     = 1'b0;
        ramEnNext     = 1'b0;
`ifdef EPRISC_ARB_RR_EN
        lastGrantNext = lastGrant;
`endif
        case (state)
            IDLE: begin
                if (|iReq) begin
                    stateNext     = ACCESS;
                    grantPortNext = winner;
                    latWriteNext  = selWrite;
                    latRamNext    = selRam;
                    memAddrNext   = selAddr;
                    memWDataNext  = selWData;
                    memWriteNext  = selWrite & selRam;
                    romEnNext     = ~selWrite & ~selRam;
                    ramEnNext     = ~selWrite & selRam;
`ifdef EPRISC_ARB_RR_EN
                    lastGrantNext = winner;
`endif
                end
            end
            ACCESS: begin
                stateNext = RESP;
            end
            RESP: begin
                stateNext          = IDLE;
                ackNext[grantPort] = 1'b1;
                wrErrNext          = latWrite & ~latRam;
                if (!latWrite) begin
                    rDataNext = iMemRData;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state     <= IDLE;
            grantPort <= 1'b0;
            latWrite  <= 1'b0;
            latRam    <= 1'b0;
            oAck      <= 2'b00;
            oRData    <= '0;
            oWrErr    <= 1'b0;
            oMemAddr  <= '0;
            oMemWData <= '0;
            oMemWrite <= 1'b0;
            oRomEn    <= 1'b0;
            oRamEn    <= 1'b0;
`ifdef EPRISC_ARB_RR_EN
            lastGrant <= 1'b1;
`endif
        end else begin
            state     <= stateNext;
            grantPort <= grantPortNext;
            latWrite  <= latWriteNext;
            latRam    <= latRamNext;
            oAck      <= ackNext;
            oRData    <= rDataNext;
            oWrErr    <= wrErrNext;
            oMemAddr  <= memAddrNext;
            oMemWData <= memWDataNext;
            oMemWrite <= memWriteNext;
            oRomEn    <= romEnNext;
            oRamEn    <= ramEnNext;
`ifdef EPRISC_ARB_RR_EN
            lastGrant <= lastGrantNext;
`endif
        end
    end

endmodule

// File: tb/tb_eprisc_bus_arbiter.sv
// Directed scoreboard bench for eprisc_bus_arbiter with a synchronous memory model.
// Honours EPRISC_ARB_RR_EN for the expected grant order under contention.
module tb_eprisc_bus_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 9;

    logic          iClk = 1'b0;
    logic          iRst;
    logic [1:0]    iReq;
    logic [1:0]    iWrite;
    logic [AW-1:0] iAddr0, iAddr1;
    logic [DW-1:0] iWData0, iWData1;
    logic [1:0]    oAck;
    logic [DW-1:0] oRData;
    logic          oWrErr;
    logic [AW-1:0] oMemAddr;
    logic [DW-1:0] oMemWData;
    logic          oMemWrite, oRomEn, oRamEn;
    logic [DW-1:0] iMemRData;

    typedef struct packed {
        logic [1:0]    ack;
        logic [DW-1:0] rd;
        logic          wrErr;
    } expT;

    expT sb[$];
    int  total = 0;
    int  bad   = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    eprisc_bus_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWrite(iWrite),
        .iAddr0(iAddr0), .iAddr1(iAddr1), .iWData0(iWData0), .iWData1(iWData1),
        .oAck(oAck), .oRData(oRData), .oWrErr(oWrErr), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .oMemWrite(oMemWrite), .oRomEn(oRomEn),
        .oRamEn(oRamEn), .iMemRData(iMemRData)
    );

    always #5 iClk = ~iClk;

    // Memory: read data valid one cycle after the enable is sampled.
    always @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            iMemRData   <= '0;
            mem[9'h105] <= 32'hDEADBEEF;
            mem[9'h004] <= 32'h12345678;
            mem[9'h120] <= 32'h11110000;
            mem[9'h121] <= 32'h22220001;
        end else begin
            if (oMemWrite) mem[oMemAddr] <= oMemWData;
            if (oRomEn || oRamEn) iMemRData <= mem[oMemAddr];
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] allOuts();
        return 128'({oAck, oWrErr, oMemWrite, oRomEn, oRamEn, oMemAddr, oMemWData, oRData});
    endfunction

    // Wait (bounded) for an ack, then pop the scoreboard and compare.
    task automatic waitAck(input int expLat, input string tag);
        int  cnt;
        expT e;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge iClk);
            cnt++;
            if (|oAck) break;
        end
        chk({tag, "_lat"}, 128'(cnt), 128'(expLat));
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_ack"}, 128'(oAck), 128'(e.ack));
            chk({tag, "_rdata"}, 128'(oRData), 128'(e.rd));
            chk({tag, "_wrerr"}, 128'(oWrErr), 128'(e.wrErr));
        end
    endtask

    // Single transfer; request dropped and inputs scrambled after latching.
    task automatic xfer(input int port, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] expRd, input string tag);
        expT  e;
        logic ram;
        ram = addr[AW-1];
        @(negedge iClk);
        iReq = 2'b00;
        iWrite = 2'b00;
        iReq[port] = 1'b1;
        iWrite[port] = wr;
        if (port == 0) begin iAddr0 = addr; iWData0 = wd; end
        else           begin iAddr1 = addr; iWData1 = wd; end
        e.ack = (port == 0) ? 2'b01 : 2'b10;
        e.rd = expRd;
        e.wrErr = wr & ~ram;
        sb.push_back(e);
        @(posedge iClk);
        @(negedge iClk);
        chk({tag, "_strobes"}, 128'({oMemWrite, oRomEn, oRamEn}),
            128'({wr & ram, ~wr & ~ram, ~wr & ram}));
        chk({tag, "_addr"}, 128'(oMemAddr), 128'(addr));
        chk({tag, "_wdata"}, 128'(oMemWData), 128'(wd));
        iReq = 2'b00;
        iWrite = 2'b11;
        iAddr0 = 9'h1FF; iAddr1 = 9'h1FF;
        iWData0 = 32'hBAD0BAD0; iWData1 = 32'hBAD1BAD1;
        @(negedge iClk);
        chk({tag, "_resp"}, 128'({oMemWrite, oRomEn, oRamEn, oAck}), 128'(0));
        waitAck(1, tag);
    endtask

    initial begin
        expT e;
        iRst = 1'b0;
        iReq = 2'b00; iWrite = 2'b00;
        iAddr0 = '0; iAddr1 = '0; iWData0 = '0; iWData1 = '0;
        repeat (3) @(negedge iClk);
        chk("reset_outs", allOuts(), 128'(0));
        iRst = 1'b1;
        @(negedge iClk);
        chk("idle_outs", allOuts(), 128'(0));

        xfer(0, 1'b0, 9'h105, 32'h0, 32'hDEADBEEF, "p0_ram_rd");
        xfer(1, 1'b1, 9'h110, 32'hA5A5A5A5, 32'hDEADBEEF, "p1_ram_wr");
        xfer(1, 1'b0, 9'h110, 32'h0, 32'hA5A5A5A5, "p1_ram_rd");
        xfer(0, 1'b0, 9'h004, 32'h0, 32'h12345678, "p0_rom_rd");
        xfer(0, 1'b1, 9'h004, 32'hFFFF0000, 32'h12345678, "p0_rom_wr");
        xfer(1, 1'b0, 9'h004, 32'h0, 32'h12345678, "p1_rom_rd_after_wr");
        repeat (4) @(negedge iClk);
        chk("rdata_hold_idle", 128'(oRData), 128'(32'h12345678));

        // Contention from reset: both ports request for four transfers.
        iRst = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        iReq = 2'b11; iWrite = 2'b00;
        iAddr0 = 9'h120; iAddr1 = 9'h121;
        for (int i = 0; i < 4; i++) begin
`ifdef EPRISC_ARB_RR_EN
            e.ack = (i % 2 == 0) ? 2'b01 : 2'b10;
            e.rd = (i % 2 == 0) ? 32'h11110000 : 32'h22220001;
`else
            e.ack = 2'b01;
            e.rd = 32'h11110000;
`endif
            e.wrErr = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < 4; i++) begin
            waitAck(3, $sformatf("contend%0d", i));
        end
        iReq = 2'b00;
        @(negedge iClk);
        @(negedge iClk);
        chk("contend_no_extra", 128'({oAck, oRomEn, oRamEn}), 128'(0));

        // Reset during ACCESS kills the transfer; held request completes later.
        iReq = 2'b10; iWrite = 2'b00; iAddr1 = 9'h105;
        @(posedge iClk);
        @(negedge iClk);
        chk("rst_access_en", 128'(oRamEn), 128'(1));
        #2 iRst = 1'b0;
        #1 chk("rst_async_outs", allOuts(), 128'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            chk($sformatf("rst_hold_noack%0d", i), 128'(oAck), 128'(0));
        end
        iRst = 1'b1;
        e.ack = 2'b10; e.rd = 32'hDEADBEEF; e.wrErr = 1'b0;
        sb.push_back(e);
        waitAck(3, "rst_retry");
        iReq = 2'b00;
        @(negedge iClk);
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
